// File: rtl/ip_msxbus_pkg.sv
// State encodings and default constants shared by the MSX cartridge I/O-cycle engine.
package ip_msxbus_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_REQ    = 3'd2;
  localparam logic [2:0] ST_DRIVE  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_REQ    = ST_REQ,
    S_DRIVE  = ST_DRIVE,
    S_FINISH = ST_FINISH
  } state_e;

  localparam logic [7:0] MSX_READ_DEFAULT = 8'hFF;

endpackage

// File: rtl/ip_sync_bus.sv
// WIDTH-bit x STAGES flip-flop synchroniser; latency STAGES clk, no backpressure.
// Resets to all-zero so strobes held through reset look asserted, not like a new edge.
module ip_sync_bus #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ip_msxbus_ioport.sv
// MSX cartridge I/O-cycle engine: sync strobes, hold WAIT during req/ack, drive TD on reads.
// WAIT rises SYNC_STAGES+1 clk after the strobe; the device stalls the Z80 via ack, bounded by WAIT_TIMEOUT.
module ip_msxbus_ioport
  import ip_msxbus_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 2,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned WAIT_TIMEOUT  = 255,
  parameter logic [7:0]  READ_DEFAULT  = MSX_READ_DEFAULT
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 n_ce,
  input  logic                 n_rd,
  input  logic                 n_wr,
  input  logic [ADDR_BITS-1:0] ta,
  input  logic [7:0]           td_in,
  output logic [7:0]           td_out,
  output logic                 tdir,
  output logic                 twait,
  output logic                 req,
  output logic                 wrt,
  output logic [ADDR_BITS-1:0] address,
  output logic [7:0]           wdata,
  input  logic                 ack,
  input  logic [7:0]           rdata,
  output logic                 timeout
);

  localparam int unsigned    BW          = ADDR_BITS + 3;
  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0]    TMO_LAST    = 16'(WAIT_TIMEOUT - 1);

  logic [BW-1:0]        s_bus;
  logic                 s_ce, s_rd, s_wr;
  logic [ADDR_BITS-1:0] s_ta;
  logic                 rd_cyc, wr_cyc, bus_idle;

  ip_sync_bus #(.WIDTH(BW), .STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .n_reset(n_reset),
    .d_i    ({n_ce, n_rd, n_wr, ta}),
    .q_o    (s_bus)
  );

  assign s_ce     = s_bus[BW-1];
  assign s_rd     = s_bus[BW-2];
  assign s_wr     = s_bus[BW-3];
  assign s_ta     = s_bus[ADDR_BITS-1:0];
  assign rd_cyc   = !s_ce && !s_rd;
  assign wr_cyc   = !s_ce && !s_wr;
  assign bus_idle = s_ce && s_rd && s_wr;

  state_e               state_q, state_d;
  logic [3:0]           settle_cnt_q, settle_cnt_d;
  logic [15:0]          tmo_cnt_q, tmo_cnt_d;
  logic [7:0]           td_out_q, td_out_d, wdata_q, wdata_d;
  logic                 tdir_q, tdir_d, twait_q, twait_d, req_q, req_d;
  logic                 wrt_q, wrt_d, timeout_q, timeout_d, armed_q, armed_d;
  logic [ADDR_BITS-1:0] address_q, address_d;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      td_out_q     <= '0;
      wdata_q      <= '0;
      tdir_q       <= 1'b0;
      twait_q      <= 1'b0;
      req_q        <= 1'b0;
      wrt_q        <= 1'b0;
      timeout_q    <= 1'b0;
      armed_q      <= 1'b0;
      address_q    <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      td_out_q     <= td_out_d;
      wdata_q      <= wdata_d;
      tdir_q       <= tdir_d;
      twait_q      <= twait_d;
      req_q        <= req_d;
      wrt_q        <= wrt_d;
      timeout_q    <= timeout_d;
      armed_q      <= armed_d;
      address_q    <= address_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    td_out_d     = td_out_q;
    wdata_d      = wdata_q;
    tdir_d       = tdir_q;
    twait_d      = twait_q;
    req_d        = req_q;
    wrt_d        = wrt_q;
    timeout_d    = 1'b0;
    address_d    = address_q;
    // After reset no cycle may start until the bus has been seen fully released.
    armed_d      = armed_q || bus_idle;
    case (state_q)
      S_IDLE: begin
        if (armed_q && rd_cyc && wr_cyc) begin
          state_d = S_FINISH;
        end else if (armed_q && (rd_cyc || wr_cyc)) begin
          state_d      = S_SETTLE;
          twait_d      = 1'b1;
          settle_cnt_d = '0;
        end
      end
      S_SETTLE: begin
        if (!(rd_cyc ^ wr_cyc)) begin
          state_d = S_IDLE;
          twait_d = 1'b0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          address_d = s_ta;
          wdata_d   = td_in;
          wrt_d     = wr_cyc;
          req_d     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = S_REQ;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      S_REQ: begin
        if (ack || tmo_cnt_q == TMO_LAST) begin
          req_d     = 1'b0;
          twait_d   = 1'b0;
          tmo_cnt_d = '0;
          timeout_d = !ack;
          if (wrt_q) begin
            state_d = S_FINISH;
          end else begin
            td_out_d = ack ? rdata : READ_DEFAULT;
            tdir_d   = 1'b1;
            state_d  = S_DRIVE;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      S_DRIVE: begin
        if (!rd_cyc) begin
          tdir_d  = 1'b0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        if (bus_idle) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign td_out  = td_out_q;
  assign tdir    = tdir_q;
  assign twait   = twait_q;
  assign req     = req_q;
  assign wrt     = wrt_q;
  assign address = address_q;
  assign wdata   = wdata_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ip_msxbus_ioport.sv
// Bench for ip_msxbus_ioport: vector table of bus cycles plus hand-written glitch/illegal/reset sequences.
module tb_ip_msxbus_ioport;

  logic       clk = 1'b0;
  logic       n_reset, n_ce, n_rd, n_wr, ack;
  logic [1:0] ta, address;
  logic [7:0] td_in, td_out, rdata, wdata;
  logic       tdir, twait, req, wrt, timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       wrt;
    logic [1:0] addr;
    logic [7:0] wdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic       rd;
    logic [1:0] addr;
    logic [7:0] wd;
    logic [7:0] rdat;
    int         ack_dly;   // REQ cycle index at which ack is given; -1 = never
    logic [7:0] exp_td;
    logic       exp_tmo;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  ip_msxbus_ioport #(.WAIT_TIMEOUT(16)) dut (
    .clk(clk), .n_reset(n_reset), .n_ce(n_ce), .n_rd(n_rd), .n_wr(n_wr), .ta(ta),
    .td_in(td_in), .td_out(td_out), .tdir(tdir), .twait(twait), .req(req), .wrt(wrt),
    .address(address), .wdata(wdata), .ack(ack), .rdata(rdata), .timeout(timeout)
  );

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%0h want=%0h", tag, nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rising req must match the next pushed expectation.
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (req && !req_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb.unexpected_req got addr=%0h wrt=%0h want=none", address, wrt);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb", "wrt", wrt, e.wrt);
        chk("sb", "address", address, e.addr);
        if (e.wrt) chk("sb", "wdata", wdata, e.wdata);
      end
    end
    req_prev = req;
  end

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int exp_n;
    ta    = v.addr;
    td_in = v.wd;
    rdata = ~v.rdat;
    n_ce  = 1'b0;
    if (v.rd) n_rd = 1'b0; else n_wr = 1'b0;
    sb_q.push_back(exp_t'{wrt: !v.rd, addr: v.addr, wdata: v.wd});
    n = 0;
    while (!twait && n < 10) begin tick(); n++; end
    chk(tag, "twait_lat", n, 3);
    n = 0;
    while (!req && n < 20) begin tick(); n++; end
    chk(tag, "req_lat", n, 3);
    chk(tag, "twait_in_req", twait, 1);
    n = 0;
    while (req && n < 40) begin
      if (n == v.ack_dly) begin ack = 1'b1; rdata = v.rdat; end
      tick();
      ack   = 1'b0;
      rdata = ~v.rdat;
      n++;
    end
    exp_n = (v.ack_dly < 0) ? 16 : v.ack_dly + 1;
    chk(tag, "req_cycles", n, exp_n);
    chk(tag, "twait_rel", twait, 0);
    chk(tag, "timeout", timeout, v.exp_tmo);
    chk(tag, "tdir", tdir, v.rd);
    chk(tag, "td_out", td_out, v.exp_td);
    tick();
    chk(tag, "timeout_clr", timeout, 0);
    if (v.rd) begin
      ack   = 1'b1;
      rdata = 8'h11;
      tick();
      ack   = 1'b0;
      tick();
      tick();
      chk(tag, "tdir_hold", tdir, 1);
      chk(tag, "td_hold", td_out, v.exp_td);
    end
    n_ce = 1'b1;
    n_rd = 1'b1;
    n_wr = 1'b1;
    if (v.rd) begin
      n = 0;
      while (tdir && n < 10) begin tick(); n++; end
      chk(tag, "tdir_fall", n, 3);
    end
    repeat (4) tick();
    chk(tag, "twait_idle", twait, 0);
  endtask

  initial begin
    int  n;
    bit  seen_req, seen_wait, seen_dir;

    vecs[0] = '{rd: 1'b0, addr: 2'd1, wd: 8'h5A, rdat: 8'h00, ack_dly: 4,  exp_td: 8'h00, exp_tmo: 1'b0};
    vecs[1] = '{rd: 1'b1, addr: 2'd0, wd: 8'h00, rdat: 8'hC3, ack_dly: 10, exp_td: 8'hC3, exp_tmo: 1'b0};
    vecs[2] = '{rd: 1'b1, addr: 2'd2, wd: 8'h00, rdat: 8'h3C, ack_dly: -1, exp_td: 8'hFF, exp_tmo: 1'b1};
    vecs[3] = '{rd: 1'b0, addr: 2'd3, wd: 8'hA5, rdat: 8'h00, ack_dly: -1, exp_td: 8'hFF, exp_tmo: 1'b1};
    vecs[4] = '{rd: 1'b1, addr: 2'd3, wd: 8'h00, rdat: 8'h00, ack_dly: 0,  exp_td: 8'h00, exp_tmo: 1'b0};
    vecs[5] = '{rd: 1'b0, addr: 2'd2, wd: 8'h81, rdat: 8'h00, ack_dly: 15, exp_td: 8'h00, exp_tmo: 1'b0};
    vecs[6] = '{rd: 1'b1, addr: 2'd1, wd: 8'h00, rdat: 8'h7E, ack_dly: 15, exp_td: 8'h7E, exp_tmo: 1'b0};

    n_reset = 1'b0;
    n_ce = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    ta = 2'd0; td_in = 8'h00; ack = 1'b0; rdata = 8'h00;
    repeat (3) tick();
    chk("rst", "td_out", td_out, 0);
    chk("rst", "tdir", tdir, 0);
    chk("rst", "twait", twait, 0);
    chk("rst", "req", req, 0);
    chk("rst", "wrt", wrt, 0);
    chk("rst", "address", address, 0);
    chk("rst", "wdata", wdata, 0);
    chk("rst", "timeout", timeout, 0);
    n_reset = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Glitch: read strobe shorter than sync + settle.
    n_ce = 1'b0; n_rd = 1'b0;
    tick(); tick();
    n_ce = 1'b1; n_rd = 1'b1;
    seen_req = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); if (req) seen_req = 1'b1; end
    chk("glitch", "req_seen", seen_req, 0);
    chk("glitch", "twait", twait, 0);

    // Illegal: read and write together.
    n_ce = 1'b0; n_rd = 1'b0; n_wr = 1'b0;
    seen_req = 1'b0; seen_wait = 1'b0; seen_dir = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (req) seen_req = 1'b1;
      if (twait) seen_wait = 1'b1;
      if (tdir) seen_dir = 1'b1;
    end
    chk("illegal", "req_seen", seen_req, 0);
    chk("illegal", "twait_seen", seen_wait, 0);
    chk("illegal", "tdir_seen", seen_dir, 0);
    n_ce = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    repeat (5) tick();

    // Reset in the middle of a read's REQ phase, strobes held across it.
    ta = 2'd2; td_in = 8'h00;
    n_ce = 1'b0; n_rd = 1'b0;
    sb_q.push_back(exp_t'{wrt: 1'b0, addr: 2'd2, wdata: 8'h00});
    n = 0;
    while (!req && n < 20) begin tick(); n++; end
    chk("rstmid", "req_up", req, 1);
    repeat (3) tick();
    chk("rstmid", "twait_pre", twait, 1);
    n_reset = 1'b0;
    tick();
    chk("rstmid", "req", req, 0);
    chk("rstmid", "twait", twait, 0);
    chk("rstmid", "tdir", tdir, 0);
    tick();
    n_reset = 1'b1;
    seen_req = 1'b0; seen_wait = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (req) seen_req = 1'b1;
      if (twait) seen_wait = 1'b1;
    end
    chk("rstmid", "held_req", seen_req, 0);
    chk("rstmid", "held_twait", seen_wait, 0);
    n_ce = 1'b1; n_rd = 1'b1;
    repeat (5) tick();
    run_vec(vecs[1], "recover");

    chk("end", "sb_left", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/ip_msxbus_ioport.md
Name: ip_msxbus_ioport

Overview:
Parametrised I/O-cycle engine for the MSX cartridge connector. It synchronises the asynchronous /CE, /RD, /WR, TA and TD signals into the clk domain and holds the Z80 with WAIT while an internal device (VDP, debugger, PSG) completes a req/ack transaction. During read cycles it drives TD and TDIR. It is the generalised successor of the fixed two-bit, always-input cartridge glue in the top level, and it sits between the cartridge pins and the internal register-port devices.

Parameters:
ADDR_BITS, 2, width of ta and of the internal address bus
SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2)
SETTLE_CYCLES, 3, clk cycles after the strobe is detected before ta/td are latched (1..15)
WAIT_TIMEOUT, 255, maximum clk cycles spent in REQ before the cycle is aborted (1..65535)
READ_DEFAULT, 8'hFF, data driven on a read that times out

Ports:
clk  in  1  system clock (86.4 MHz)
n_reset  in  1  reset; synchronous, active-low
n_ce  in  1  cartridge chip enable, asynchronous, active-low
n_rd  in  1  read strobe, asynchronous, active-low
n_wr  in  1  write strobe, asynchronous, active-low
ta  in  ADDR_BITS  cartridge address, asynchronous
td_in  in  8  TD pin input
td_out  out  8  TD pin output value
tdir  out  1  1 = drive TD (read cycle)
twait  out  1  WAIT request to the Z80, 1 = hold
req  out  1  transaction request to the internal device
wrt  out  1  1 = write transaction, qualified by req
address  out  ADDR_BITS  latched ta
wdata  out  8  latched td_in
ack  in  1  device done; rdata is valid in the same cycle
rdata  in  8  device read data
timeout  out  1  one-cycle pulse when a cycle is aborted

Behaviour:
- Reset: on any clk edge with n_reset=0, all state returns to IDLE. Reset values: td_out=0, tdir=0, twait=0, req=0, wrt=0, address=0, wdata=0, timeout=0, counters=0. Reset applied mid-cycle releases twait and tdir on the next edge.
- Sync: n_ce, n_rd, n_wr and ta pass through SYNC_STAGES flip-flops. td_in is sampled only at latch time; it is not synchronised.
- Strobe: rd_cyc = !s_ce & !s_rd; wr_cyc = !s_ce & !s_wr.
- FSM states: IDLE, SETTLE, REQ, DRIVE, FINISH.
- IDLE:
  - rd_cyc XOR wr_cyc → SETTLE. twait=1 from the next edge. Latency from the pin edge is SYNC_STAGES+1 clk cycles.
  - Both rd_cyc and wr_cyc → FINISH with no request and twait=0. This is an illegal cycle.
- SETTLE: count SETTLE_CYCLES. On the final count, latch address<=s_ta, wdata<=td_in and wrt<=wr_cyc, then → REQ with req=1.
  - If the strobe is lost before the final count → IDLE, twait=0, no request issued.
- REQ: req stays high until ack, for exactly one transaction per bus cycle.
  - On ack, req=0 next edge.
  - Read: td_out<=rdata, tdir=1, → DRIVE.
  - Write: → FINISH.
  - In both cases twait=0 on the next edge.
  - The timeout counter increments each REQ cycle. On reaching WAIT_TIMEOUT without ack: req=0, timeout=1 for one cycle, and a read uses td_out=READ_DEFAULT, then → DRIVE (read) or FINISH (write).
  - ack arriving in the same cycle the count reaches WAIT_TIMEOUT: ack wins and no timeout is signalled.
- DRIVE: tdir=1 and td_out are held until rd_cyc deasserts, then tdir=0 next edge, → FINISH.
- FINISH: wait until s_ce, s_rd and s_wr are all 1, then → IDLE. This guarantees no re-trigger within one Z80 cycle.
- ack outside REQ is ignored.
- td_out keeps its last value when tdir=0.

Decomposition:
- Shared package ip_msxbus_pkg holds the FSM state encoding (3-bit localparams ST_IDLE..ST_FINISH) and the default READ_DEFAULT constant.
- One sub-module, ip_sync_bus (parametrised width × SYNC_STAGES flip-flop chain). It is instantiated once for {n_ce,n_rd,n_wr,ta}.

Test Plan:
- Write: ta=2'b01, td_in=8'h5A, n_ce=n_wr=0, device acks after 4 cycles → exactly one req with wrt=1, address=1, wdata=8'h5A. twait rises 3 clks after the strobe and falls 1 clk after ack.
- Read: n_ce=n_rd=0, ta=0, ack with rdata=8'hC3 after 10 cycles → tdir=1, td_out=8'hC3 until n_rd rises. tdir=0 one clk after the synced rise, and only one req is issued.
- Timeout: WAIT_TIMEOUT=16, read with ack never asserted → req drops after 16 REQ cycles, one timeout pulse, td_out=8'hFF, twait=0.
- Glitch: n_rd low for 2 clks (shorter than sync+settle) → no req, twait back to 0, FSM in IDLE.
- Illegal: n_rd and n_wr asserted together with n_ce=0 → no req, twait stays 0 and tdir=0 until all three strobes are released.
- Reset mid-cycle: n_reset=0 during REQ of a read → next edge req=0, twait=0, tdir=0. After release, the held strobes do not start a new cycle until all three strobes are released.
